thor2022_icache_refill: RTL and testbench

Instruction-cache miss/refill controller that sits directly upstream of the I-cache valid-bit array and the line data RAM. On a miss it picks a victim way and fetches the 64-byte line as a 4-beat, 128-bit bus burst. It assembles the line, then issues a one-cycle write strobe with way and address. That strobe sets the valid bit and writes the data RAM. Invalidations that overlap an in-flight fill suppress the final valid write.

---
 rtl/thor2022_icache_refill_pkg.sv | 25 ++
 rtl/thor2022_icache_refill_victim_sel.sv | 23 ++
 rtl/thor2022_icache_refill.sv | 154 +++++++++++++++
 tb/tb_thor2022_icache_refill.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2022_icache_refill_pkg.sv
// Shared types and geometry constants for the I-cache refill controller.
// The line geometry is fixed: 64-byte lines fetched as four 128-bit beats.
package thor2022_icache_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_ABORT = 2'd3
  } refill_state_e;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned BEAT_BYTES = LINE_BYTES / BEATS;
  localparam int unsigned BEAT_BITS  = BEAT_BYTES * 8;

  // Line index occupies adr[12:6].
  localparam int unsigned IDX_LO     = 6;
  localparam int unsigned IDX_HI     = 12;

  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned OFS_W      = $clog2(BEAT_BYTES);
  localparam int unsigned LINE_OFS_W = $clog2(LINE_BYTES);

endpackage

// File: rtl/thor2022_icache_refill_victim_sel.sv
// Victim way selection: lowest-index invalid way, else the round-robin pointer.
// Purely combinational.
module thor2022_victim_sel #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-1:0]         i_line_valid,
  input  logic [$clog2(WAYS)-1:0] i_ptr,
  output logic [$clog2(WAYS)-1:0] o_victim,
  output logic                    o_all_valid
);

  localparam int unsigned WW = $clog2(WAYS);

  always_comb begin
    o_all_valid = &i_line_valid;
    o_victim    = i_ptr;
    // Scan from the top so the lowest invalid way is the last one written.
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!i_line_valid[w-1]) o_victim = WW'(w - 1);
    end
  end

endmodule

// File: rtl/thor2022_icache_refill.sv
// I-cache miss/refill controller: picks a victim way, bursts the line in four
// beats, then issues a single write strobe unless an invalidate killed the fill.
module thor2022_icache_refill
  import thor2022_icache_refill_pkg::*;
#(
  parameter int unsigned AWID  = 32,
  parameter int unsigned WAYS  = 4,
  parameter int unsigned LINES = 128,
  parameter int unsigned TMO   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss,
  input  logic [AWID-1:0]           miss_adr,
  input  logic [WAYS-1:0]           line_valid,
  input  logic                      invce,
  input  logic                      invline,
  input  logic                      invall,
  input  logic [AWID-1:0]           inv_adr,
  output logic                      bus_cyc,
  output logic                      bus_stb,
  output logic [AWID-1:0]           bus_adr,
  input  logic                      bus_ack,
  input  logic                      bus_err,
  input  logic [BEAT_BITS-1:0]      bus_dat,
  output logic                      busy,
  output logic                      wr,
  output logic [$clog2(WAYS)-1:0]   wr_way,
  output logic [AWID-1:0]           wr_adr,
  output logic [BEAT_BITS*BEATS-1:0] line,
  output logic                      err
);

  localparam int unsigned WW    = $clog2(WAYS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TW    = $clog2(TMO + 1);
  localparam int unsigned LW    = BEAT_BITS * BEATS;

  refill_state_e           r_state;
  refill_state_e           w_next;
  logic [AWID-1:LINE_OFS_W] r_line_adr;
  logic [BEAT_W-1:0]       r_beat;
  logic [TW-1:0]           r_tmo;
  logic                    r_kill;
  logic                    r_allv;
  logic [WW-1:0]           r_way;
  logic [WW-1:0]           r_ptr;
  logic [LW-1:0]           r_line;
  logic [WW-1:0]           w_victim;
  logic                    w_allv;
  logic                    w_inv_hit;
  logic                    w_last_beat;
  logic                    w_unused;

  thor2022_victim_sel #(
    .WAYS (WAYS)
  ) u_victim_sel (
    .i_line_valid (line_valid),
    .i_ptr        (r_ptr),
    .o_victim     (w_victim),
    .o_all_valid  (w_allv)
  );

  assign w_inv_hit = invce &
                     (invall |
                      (invline & (inv_adr[IDX_LO +: IDX_W] == r_line_adr[IDX_LO +: IDX_W])));

  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

  assign w_unused = ^{miss_adr[LINE_OFS_W-1:0],
                      inv_adr[AWID-1:IDX_LO+IDX_W],
                      inv_adr[IDX_LO-1:0]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (miss) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        // A bus error outranks an ack on the same beat.
        if (bus_err) begin
          w_next = ST_ABORT;
        end else if (bus_ack) begin
          if (w_last_beat) w_next = ST_WRITE;
        end else if (r_tmo == TW'(TMO)) begin
          w_next = ST_ABORT;
        end
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_ABORT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_line_adr <= '0;
      r_beat     <= '0;
      r_tmo      <= '0;
      r_kill     <= 1'b0;
      r_allv     <= 1'b0;
      r_way      <= '0;
      r_ptr      <= '0;
      r_line     <= '0;
    end else begin
      r_state <= w_next;

      if ((r_state != ST_IDLE) && w_inv_hit) r_kill <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (miss) begin
            r_line_adr <= miss_adr[AWID-1:LINE_OFS_W];
            r_way      <= w_victim;
            r_allv     <= w_allv;
            r_beat     <= '0;
            r_tmo      <= '0;
            r_kill     <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (!bus_err) begin
            if (bus_ack) begin
              r_line[r_beat*BEAT_BITS +: BEAT_BITS] <= bus_dat;
              r_beat <= r_beat + 1'b1;
              r_tmo  <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // Replacement pointer only advances when it actually chose the victim.
          if (r_allv) r_ptr <= (r_ptr == WW'(WAYS - 1)) ? '0 : r_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_cyc = (r_state == ST_FETCH);
  assign bus_stb = (r_state == ST_FETCH);
  assign bus_adr = {r_line_adr, r_beat, {OFS_W{1'b0}}};
  assign busy    = (r_state != ST_IDLE);
  // An invalidate landing in the write cycle itself must still suppress the strobe.
  assign wr      = (r_state == ST_WRITE) & ~r_kill & ~w_inv_hit;
  assign wr_way  = r_way;
  assign wr_adr  = {r_line_adr, {LINE_OFS_W{1'b0}}};
  assign line    = r_line;
  assign err     = (r_state == ST_ABORT);

endmodule

// File: tb/tb_thor2022_icache_refill.sv
// Scoreboard bench for the I-cache refill controller: stimulus tasks push
// expected beats/writes, a negedge monitor records what the DUT produced.
module tb_thor2022_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss;
  logic [31:0]  miss_adr;
  logic [3:0]   line_valid;
  logic         invce, invline, invall;
  logic [31:0]  inv_adr;
  logic         bus_cyc, bus_stb;
  logic [31:0]  bus_adr;
  logic         bus_ack, bus_err;
  logic [127:0] bus_dat;
  logic         busy, wr, err;
  logic [1:0]   wr_way;
  logic [31:0]  wr_adr;
  logic [511:0] line;

  thor2022_icache_refill #(
    .AWID  (32),
    .WAYS  (4),
    .LINES (128),
    .TMO   (255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .miss       (miss),
    .miss_adr   (miss_adr),
    .line_valid (line_valid),
    .invce      (invce),
    .invline    (invline),
    .invall     (invall),
    .inv_adr    (inv_adr),
    .bus_cyc    (bus_cyc),
    .bus_stb    (bus_stb),
    .bus_adr    (bus_adr),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err),
    .bus_dat    (bus_dat),
    .busy       (busy),
    .wr         (wr),
    .wr_way     (wr_way),
    .wr_adr     (wr_adr),
    .line       (line),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           c;
    logic [1:0]   way;
    logic [31:0]  adr;
    logic [511:0] ln;
  } wr_t;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  wr_t         exp_wr[$], obs_wr[$];
  logic [31:0] exp_stb[$], obs_stb[$];
  int          obs_err[$], obs_rise[$], obs_fall[$];
  logic        prev_cyc  = 1'b0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t m;
    if (!rst) begin
      if (bus_stb) obs_stb.push_back(bus_adr);
      if (wr) begin
        m.c = cyc; m.way = wr_way; m.adr = wr_adr; m.ln = line;
        obs_wr.push_back(m);
      end
      if (err) obs_err.push_back(cyc);
      if (bus_cyc && !prev_cyc) obs_rise.push_back(cyc);
      if (!busy && prev_busy) obs_fall.push_back(cyc);
    end
    prev_cyc  = bus_cyc;
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    exp_wr.delete(); obs_wr.delete(); exp_stb.delete(); obs_stb.delete();
    obs_err.delete(); obs_rise.delete(); obs_fall.delete();
  endtask

  // One refill: miss for one cycle, then beat responses with `waits` idle cycles
  // before each ack. errbeat/invbeat of -1 disable; invbeat 4 = the write cycle.
  task automatic fill(input logic [31:0] adr, input logic [3:0] lv, input int waits,
                      input int errbeat, input int invbeat, input int invmode,
                      input logic [31:0] iadr, output int t_miss, output logic [511:0] ln);
    logic [127:0] d;
    ln = '0;
    @(posedge clk); #1;
    miss = 1'b1; miss_adr = adr; line_valid = lv; t_miss = cyc;
    @(posedge clk); #1;
    miss = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w <= waits; w++) begin
        exp_stb.push_back({adr[31:6], 2'(b), 4'h0});
        if (b == invbeat && w == 0) begin
          invce = 1'b1; invline = (invmode == 1); invall = (invmode == 2); inv_adr = iadr;
        end
        if (w == waits) begin
          if (b == errbeat) begin
            bus_err = 1'b1;
          end else begin
            d = {$urandom, $urandom, $urandom, $urandom};
            bus_dat = d; bus_ack = 1'b1;
            ln[128*b +: 128] = d;
          end
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_err = 1'b0; invce = 1'b0; invline = 1'b0; invall = 1'b0;
      end
      if (b == errbeat) break;
    end
    if (invbeat == 4) begin
      invce = 1'b1; invline = (invmode == 1); invall = (invmode == 2); inv_adr = iadr;
    end
    @(posedge clk); #1;
    invce = 1'b0; invline = 1'b0; invall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus_cyc !== 1'b0) begin n_fail++; $display("FAIL rst_cyc: got %b want 0", bus_cyc); end
    n_chk++; if (bus_stb !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b want 0", bus_stb); end
    n_chk++; if (bus_adr !== 32'h0) begin n_fail++; $display("FAIL rst_adr: got %h want 0", bus_adr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (wr !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_wr_err: got %b%b want 00", wr, err); end
    n_chk++; if (wr_way !== 2'd0 || wr_adr !== 32'h0) begin n_fail++; $display("FAIL rst_wrinfo: got %0d/%h want 0/0", wr_way, wr_adr); end
    n_chk++; if (line !== 512'h0) begin n_fail++; $display("FAIL rst_line: got nonzero line want 0"); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    int t; logic [511:0] ln; wr_t e, o; logic [31:0] ea, oa;
    clear_queues();
    fill(32'h0000_1234, 4'b0011, 0, -1, -1, 0, 32'h0, t, ln);
    e.c = t + 5; e.way = 2'd2; e.adr = 32'h0000_1200; e.ln = ln;
    exp_wr.push_back(e);
    n_chk++; if (obs_rise.size() != 1 || obs_rise[0] != t + 1) begin
      n_fail++; $display("FAIL zw_cyc_rise: got %0d entries first %0d want cycle %0d", obs_rise.size(), (obs_rise.size() > 0) ? obs_rise[0] : -1, t + 1);
    end
    n_chk++; if (obs_stb.size() != exp_stb.size()) begin n_fail++; $display("FAIL zw_nstb: got %0d want %0d", obs_stb.size(), exp_stb.size()); end
    while (exp_stb.size() > 0 && obs_stb.size() > 0) begin
      ea = exp_stb.pop_front(); oa = obs_stb.pop_front();
      n_chk++; if (oa !== ea) begin n_fail++; $display("FAIL zw_adr: got %h want %h", oa, ea); end
    end
    n_chk++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL zw_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_chk++; if (o.c != e.c) begin n_fail++; $display("FAIL zw_wr_cycle: got %0d want %0d", o.c, e.c); end
      n_chk++; if (o.way !== e.way) begin n_fail++; $display("FAIL zw_wr_way: got %0d want %0d", o.way, e.way); end
      n_chk++; if (o.adr !== e.adr) begin n_fail++; $display("FAIL zw_wr_adr: got %h want %h", o.adr, e.adr); end
      n_chk++; if (o.ln !== e.ln) begin n_fail++; $display("FAIL zw_line: got %h want %h", o.ln, e.ln); end
    end
    n_chk++; if (obs_err.size() != 0) begin n_fail++; $display("FAIL zw_err: got %0d pulses want 0", obs_err.size()); end
  endtask

  task automatic test_round_robin();
    logic [31:0] adrs[4];
    int t; logic [511:0] ln; wr_t e, o;
    adrs = '{32'h0000_2040, 32'h0000_3080, 32'h0000_40C0, 32'h0000_5100};
    clear_queues();
    // Pointer starts at 0, so four all-valid fills must walk 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      fill(adrs[i], 4'b1111, 0, -1, -1, 0, 32'h0, t, ln);
      e.c = t + 5; e.way = 2'(i); e.adr = {adrs[i][31:6], 6'h0}; e.ln = ln;
      exp_wr.push_back(e);
    end
    n_chk++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL rr_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_chk++; if (o.way !== e.way) begin n_fail++; $display("FAIL rr_way: got %0d want %0d", o.way, e.way); end
      n_chk++; if (o.adr !== e.adr) begin n_fail++; $display("FAIL rr_adr: got %h want %h", o.adr, e.adr); end
      n_chk++; if (o.ln !== e.ln) begin n_fail++; $display("FAIL rr_line: got %h want %h", o.ln, e.ln); end
    end
  endtask

  task automatic test_wait_states();
    int t; logic [511:0] ln; wr_t e, o; logic [31:0] ea, oa;
    clear_queues();
    fill(32'h0000_ABCD, 4'b0111, 3, -1, -1, 0, 32'h0, t, ln);
    e.c = t + 17; e.way = 2'd3; e.adr = 32'h0000_ABC0; e.ln = ln;
    exp_wr.push_back(e);
    n_chk++; if (obs_stb.size() != exp_stb.size()) begin n_fail++; $display("FAIL ws_nstb: got %0d want %0d", obs_stb.size(), exp_stb.size()); end
    while (exp_stb.size() > 0 && obs_stb.size() > 0) begin
      ea = exp_stb.pop_front(); oa = obs_stb.pop_front();
      n_chk++; if (oa !== ea) begin n_fail++; $display("FAIL ws_adr_hold: got %h want %h", oa, ea); end
    end
    n_chk++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL ws_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_chk++; if (o.c != e.c) begin n_fail++; $display("FAIL ws_wr_cycle: got %0d want %0d", o.c, e.c); end
      n_chk++; if (o.way !== e.way) begin n_fail++; $display("FAIL ws_wr_way: got %0d want %0d", o.way, e.way); end
      n_chk++; if (o.ln !== e.ln) begin n_fail++; $display("FAIL ws_line: got %h want %h", o.ln, e.ln); end
    end
  endtask

  task automatic test_bus_err();
    int t, t2; logic [511:0] ln; wr_t e, o; logic [31:0] ea, oa;
    clear_queues();
    fill(32'h0000_6600, 4'b1111, 0, 2, -1, 0, 32'h0, t, ln);
    n_chk++; if (obs_err.size() != 1 || obs_err[0] != t + 4) begin
      n_fail++; $display("FAIL err_pulse: got %0d pulses first %0d want 1 at %0d", obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : -1, t + 4);
    end
    n_chk++; if (obs_fall.size() != 1 || obs_fall[0] != t + 5) begin
      n_fail++; $display("FAIL err_busy_fall: got %0d falls first %0d want cycle %0d", obs_fall.size(), (obs_fall.size() > 0) ? obs_fall[0] : -1, t + 5);
    end
    n_chk++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL err_no_wr: got %0d writes want 0", obs_wr.size()); end
    n_chk++; if (obs_stb.size() != exp_stb.size()) begin n_fail++; $display("FAIL err_nstb: got %0d want %0d", obs_stb.size(), exp_stb.size()); end
    while (exp_stb.size() > 0 && obs_stb.size() > 0) begin
      ea = exp_stb.pop_front(); oa = obs_stb.pop_front();
      n_chk++; if (oa !== ea) begin n_fail++; $display("FAIL err_adr: got %h want %h", oa, ea); end
    end
    // Aborted fill must leave the pointer at 0 for the next all-valid fill.
    clear_queues();
    fill(32'h0000_6640, 4'b1111, 0, -1, -1, 0, 32'h0, t2, ln);
    e.c = t2 + 5; e.way = 2'd0; e.adr = 32'h0000_6640; e.ln = ln;
    exp_wr.push_back(e);
    n_chk++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL err_next_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_chk++; if (o.way !== e.way) begin n_fail++; $display("FAIL err_ptr_kept: got way %0d want %0d", o.way, e.way); end
      n_chk++; if (o.c != e.c) begin n_fail++; $display("FAIL err_next_cycle: got %0d want %0d", o.c, e.c); end
    end
  endtask

  task automatic test_invalidate();
    // {inv_adr, invbeat, invmode, expect_wr}; 0x1200 has line index 0x48.
    logic [31:0] iadr[5];
    int          ibeat[5], imode[5], ewr[5];
    int t; logic [511:0] ln; wr_t e, o;
    iadr  = '{32'h0000_3230, 32'h0000_1240, 32'h0000_0000, 32'h0000_1200, 32'h0000_1240};
    ibeat = '{1, 1, 0, 4, 4};
    imode = '{1, 1, 2, 1, 1};
    ewr   = '{0, 1, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      clear_queues();
      fill(32'h0000_1200, 4'b0011, 0, -1, ibeat[i], imode[i], iadr[i], t, ln);
      if (ewr[i] != 0) begin
        e.c = t + 5; e.way = 2'd2; e.adr = 32'h0000_1200; e.ln = ln;
        exp_wr.push_back(e);
      end
      n_chk++; if (obs_stb.size() != 4) begin n_fail++; $display("FAIL inv%0d_burst: got %0d beats want 4", i, obs_stb.size()); end
      n_chk++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL inv%0d_nwr: got %0d want %0d", i, obs_wr.size(), exp_wr.size()); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
        e = exp_wr.pop_front(); o = obs_wr.pop_front();
        n_chk++; if (o.c != e.c || o.way !== e.way || o.adr !== e.adr) begin
          n_fail++; $display("FAIL inv%0d_wr: got %0d/%0d/%h want %0d/%0d/%h", i, o.c, o.way, o.adr, e.c, e.way, e.adr);
        end
        n_chk++; if (o.ln !== e.ln) begin n_fail++; $display("FAIL inv%0d_line: got %h want %h", i, o.ln, e.ln); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int t; logic [511:0] ln; wr_t e, o;
    clear_queues();
    @(posedge clk); #1;
    miss = 1'b1; miss_adr = 32'h0000_7700; line_valid = 4'b0000;
    @(posedge clk); #1;
    miss = 1'b0; bus_ack = 1'b1; bus_dat = {4{$urandom}};
    @(posedge clk); #1;
    bus_ack = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin n_fail++; $display("FAIL rmb_cyc: got %b%b want 00", bus_cyc, bus_stb); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmb_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    n_chk++; if (obs_wr.size() != 0 || obs_err.size() != 0) begin
      n_fail++; $display("FAIL rmb_no_wr_err: got %0d wr %0d err want 0 0", obs_wr.size(), obs_err.size());
    end
    // Pointer was non-zero before reset; a fresh all-valid fill must pick way 0.
    clear_queues();
    fill(32'h0000_7700, 4'b1111, 0, -1, -1, 0, 32'h0, t, ln);
    e.c = t + 5; e.way = 2'd0; e.adr = 32'h0000_7700; e.ln = ln;
    exp_wr.push_back(e);
    n_chk++; if (obs_wr.size() != exp_wr.size()) begin n_fail++; $display("FAIL rmb_refill_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_chk++; if (o.c != e.c || o.way !== e.way || o.adr !== e.adr) begin
        n_fail++; $display("FAIL rmb_refill_wr: got %0d/%0d/%h want %0d/%0d/%h", o.c, o.way, o.adr, e.c, e.way, e.adr);
      end
      n_chk++; if (o.ln !== e.ln) begin n_fail++; $display("FAIL rmb_refill_line: got %h want %h", o.ln, e.ln); end
    end
  endtask

  initial begin
    rst = 1'b1; miss = 1'b0; miss_adr = '0; line_valid = '0;
    invce = 1'b0; invline = 1'b0; invall = 1'b0; inv_adr = '0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_dat = '0;
    test_reset();
    test_zero_wait();
    test_round_robin();
    test_wait_states();
    test_bus_err();
    test_invalidate();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
